thr_set_ctrl: RTL and testbench
===============================

THR_SET_CTRL -- requirements
Module: thr_set_ctrl

Interface
REQ-001 Parameter: CNT_W, 20, width of per-frame hit counter.
REQ-002 Parameter: DEF_Y_MIN/DEF_Y_MAX/DEF_CB_MIN/DEF_CB_MAX/DEF_CR_MIN/DEF_CR_MAX, 50/200/133/173/77/127, reset value of every threshold register.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_we  input  1  config write strobe, one write per cycle.
REQ-006 cfg_addr  input  5  [4:3] set index 0-3, [2:0] register index (0 y_min, 1 y_max, 2 cb_min, 3 cb_max, 4 cr_min, 5 cr_max).
REQ-007 cfg_wdata  input  8  config write data.
REQ-008 sel_set  input  2  set to activate at next frame when scan_en=0.
REQ-009 scan_en  input  1  1 = auto-advance active set every frame.
REQ-010 in_vs, in_de  input  1 each  video timing of stream entering threshold datapath; in_vs active-high.
REQ-011 thr_data, thr_de  input  1 each  match bit and valid returned from threshold datapath.
REQ-012 y_min, y_max, cb_min, cb_max, cr_min, cr_max  output  8 each  active thresholds driven to datapath.
REQ-013 act_set  output  2  index of set currently active.
REQ-014 frame_start  output  1  one-cycle pulse at each frame boundary.
REQ-015 hit_cnt  output  CNT_W  matched-pixel count of last completed frame.
REQ-016 hit_set  output  2  set that was active during the frame reported in hit_cnt.
REQ-017 hit_valid  output  1  one-cycle pulse when hit_cnt/hit_set update.
REQ-018 cfg_err  output  1  one-cycle pulse on write to register index 6 or 7.

Function
REQ-019 Block SHALL hold 4 shadow sets x 6 registers, written only via cfg_we; writes to index 6/7 SHALL be discarded and pulse cfg_err the following cycle.
REQ-020 Frame boundary SHALL be detected as in_vs=1 with registered previous in_vs=0; frame_start SHALL be registered high for exactly the cycle after that clock edge.
REQ-021 On the boundary edge, next set SHALL be act_set+1 (3 wraps to 0) if scan_en=1, else sel_set; act_set and all six threshold outputs SHALL load from that shadow set on the same edge.
REQ-022 Threshold outputs SHALL never change except at a boundary edge or reset; shadow writes mid-frame SHALL not affect outputs until the next boundary.
REQ-023 Write on the boundary cycle targeting the set being loaded SHALL bypass: outputs take cfg_wdata for the written register, shadow also updated.
REQ-024 Hit counter SHALL increment by 1 on each cycle with thr_de=1 and thr_data=1, saturating at 2^CNT_W-1 (no wrap).
REQ-025 FSM states: WAIT_FRAME (no boundary seen since reset), RUN. WAIT_FRAME -> RUN on first boundary with no hit_valid; RUN stays RUN.
REQ-026 In RUN, on each boundary: hit_cnt <= counter, hit_set <= act_set before update, hit_valid pulses one cycle, counter restarts.
REQ-027 Hit on the boundary cycle itself SHALL count toward the new frame (counter loads 1, not 0).
REQ-028 Hits in WAIT_FRAME SHALL be ignored (counter held at 0).
REQ-029 sel_set/scan_en changes SHALL be sampled only on boundary edges.

Reset
REQ-030 On rst_n low, asynchronously: all shadow and active registers to DEF_* values, act_set=0, hit_cnt=0, hit_set=0, counter=0, frame_start=hit_valid=cfg_err=0, FSM=WAIT_FRAME, registered in_vs=0.
REQ-031 Reset mid-frame SHALL discard partial count and configuration; an in_vs already high at release SHALL be treated as a boundary on the first clock.

Verification
REQ-032 Reset, no writes, one in_vs pulse -> outputs 50/200/133/173/77/127, act_set=0, frame_start pulse, no hit_valid.
REQ-033 Write set 2 y_min=90, sel_set=2, two frames with 1000 hits in second -> y_min=90 after first boundary; hit_valid with hit_cnt=1000, hit_set=2 at third boundary.
REQ-034 scan_en=1 over 5 frames -> act_set 1,2,3,0,1; hit_set lags act_set by one frame.
REQ-035 Write set 1 cr_max=140 on boundary cycle while activating set 1 -> cr_max=140 next cycle; write to cfg_addr=5'b01110 -> cfg_err pulse, no register changes.
REQ-036 CNT_W=4, 20 hits in a frame -> hit_cnt=15; hit coincident with boundary -> next frame count includes it.

Source files
------------

// File: rtl/thr_set_ctrl.sv
// Threshold set controller: holds four shadow sets of YCbCr window
// thresholds, swaps the active set only at frame boundaries, and reports
// the per-frame count of matched pixels together with the set that was
// active while they were counted.
module thr_set_ctrl #(
    parameter int         CNT_W      = 20,
    parameter logic [7:0] DEF_Y_MIN  = 8'd50,
    parameter logic [7:0] DEF_Y_MAX  = 8'd200,
    parameter logic [7:0] DEF_CB_MIN = 8'd133,
    parameter logic [7:0] DEF_CB_MAX = 8'd173,
    parameter logic [7:0] DEF_CR_MIN = 8'd77,
    parameter logic [7:0] DEF_CR_MAX = 8'd127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic [1:0]       sel_set,
    input  logic             scan_en,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic             thr_data,
    input  logic             thr_de,
    output logic [7:0]       y_min,
    output logic [7:0]       y_max,
    output logic [7:0]       cb_min,
    output logic [7:0]       cb_max,
    output logic [7:0]       cr_min,
    output logic [7:0]       cr_max,
    output logic [1:0]       act_set,
    output logic             frame_start,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       hit_set,
    output logic             hit_valid,
    output logic             cfg_err,
    output logic             fsm_state
);

    localparam int NREG = 6;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             boundary;
    logic             hit;
    logic             wr_ok;
    logic             do_report;
    logic             cnt_en;
    logic [1:0]       wr_set;
    logic [2:0]       wr_reg;
    logic [1:0]       next_set;
    logic [7:0]       shd     [4][NREG];
    logic [7:0]       act_thr [NREG];
    logic [7:0]       ld_val  [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic             unused_in_de;

    // Pixel-enable of the incoming stream is not needed: matches arrive
    // already qualified by thr_de.
    assign unused_in_de = in_de;

    function automatic logic [7:0] def_val(input int r);
        case (r)
            0:       def_val = DEF_Y_MIN;
            1:       def_val = DEF_Y_MAX;
            2:       def_val = DEF_CB_MIN;
            3:       def_val = DEF_CB_MAX;
            4:       def_val = DEF_CR_MIN;
            default: def_val = DEF_CR_MAX;
        endcase
    endfunction

    assign boundary = in_vs & ~vs_q;
    assign hit      = thr_de & thr_data;
    assign wr_set   = cfg_addr[4:3];
    assign wr_reg   = cfg_addr[2:0];
    assign wr_ok    = cfg_we && (wr_reg < 3'd6);
    assign next_set = scan_en ? (act_set + 2'd1) : sel_set;

    assign y_min     = act_thr[0];
    assign y_max     = act_thr[1];
    assign cb_min    = act_thr[2];
    assign cb_max    = act_thr[3];
    assign cr_min    = act_thr[4];
    assign cr_max    = act_thr[5];
    assign fsm_state = state_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_FRAME;
        else        state_q <= state_d;
    end

    // FSM next state: leave WAIT_FRAME on the first boundary, then stay in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (boundary) state_d = RUN;
            RUN:        state_d = RUN;
        endcase
    end

    // FSM outputs: counting is enabled only in RUN; boundaries in RUN report
    always_comb begin
        cnt_en    = (state_q == RUN);
        do_report = boundary && (state_q == RUN);
    end

    // Values loaded into the active set; a same-edge write to that set wins
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            ld_val[r] = shd[next_set][r];
            if (wr_ok && (wr_set == next_set) && (wr_reg == 3'(r)))
                ld_val[r] = cfg_wdata;
        end
    end

    // Shadow register file, written only through the config port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++)
                for (int r = 0; r < NREG; r++)
                    shd[s][r] <= def_val(r);
        end else if (wr_ok) begin
            for (int s = 0; s < 4; s++)
                for (int r = 0; r < NREG; r++)
                    if ((wr_set == 2'(s)) && (wr_reg == 3'(r)))
                        shd[s][r] <= cfg_wdata;
        end
    end

    // Active thresholds and set index change only on a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_set <= 2'd0;
            for (int r = 0; r < NREG; r++)
                act_thr[r] <= def_val(r);
        end else if (boundary) begin
            act_set <= next_set;
            for (int r = 0; r < NREG; r++)
                act_thr[r] <= ld_val[r];
        end
    end

    // Frame-edge detect, frame_start pulse and bad-address error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            frame_start <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            vs_q        <= in_vs;
            frame_start <= boundary;
            cfg_err     <= cfg_we && (wr_reg >= 3'd6);
        end
    end

    // Saturating hit counter; a boundary starts a new frame including its own hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (boundary) begin
            cnt_q <= hit ? CNT_W'(1) : '0;
        end else if (cnt_en && hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Per-frame report captured at each boundary seen in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            hit_set   <= 2'd0;
            hit_valid <= 1'b0;
        end else begin
            hit_valid <= do_report;
            if (do_report) begin
                hit_cnt <= cnt_q;
                hit_set <= act_set;
            end
        end
    end

endmodule

// File: tb/tb_thr_set_ctrl.sv
// Directed bench for thr_set_ctrl. A second instance with a 4-bit counter
// shares all inputs so counter saturation can be observed alongside the
// full-width count.
module tb_thr_set_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [1:0]  sel_set;
    logic        scan_en;
    logic        in_vs;
    logic        in_de;
    logic        thr_data;
    logic        thr_de;

    logic [7:0]  y_min, y_max, cb_min, cb_max, cr_min, cr_max;
    logic [1:0]  act_set, hit_set;
    logic        frame_start, hit_valid, cfg_err, fsm_state;
    logic [19:0] hit_cnt;

    logic [7:0]  thr4 [6];
    logic [1:0]  act_set4, hit_set4;
    logic        frame_start4, hit_valid4, cfg_err4, fsm_state4;
    logic [3:0]  hit_cnt4;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [1:0]  prev_act;
    logic [1:0]  exp_act;

    thr_set_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .sel_set(sel_set), .scan_en(scan_en),
        .in_vs(in_vs), .in_de(in_de), .thr_data(thr_data), .thr_de(thr_de),
        .y_min(y_min), .y_max(y_max), .cb_min(cb_min), .cb_max(cb_max),
        .cr_min(cr_min), .cr_max(cr_max), .act_set(act_set),
        .frame_start(frame_start), .hit_cnt(hit_cnt), .hit_set(hit_set),
        .hit_valid(hit_valid), .cfg_err(cfg_err), .fsm_state(fsm_state)
    );

    thr_set_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .sel_set(sel_set), .scan_en(scan_en),
        .in_vs(in_vs), .in_de(in_de), .thr_data(thr_data), .thr_de(thr_de),
        .y_min(thr4[0]), .y_max(thr4[1]), .cb_min(thr4[2]), .cb_max(thr4[3]),
        .cr_min(thr4[4]), .cr_max(thr4[5]), .act_set(act_set4),
        .frame_start(frame_start4), .hit_cnt(hit_cnt4), .hit_set(hit_set4),
        .hit_valid(hit_valid4), .cfg_err(cfg_err4), .fsm_state(fsm_state4)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_thr(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] e, input logic [7:0] f);
        chk({tag, ".y_min"},  y_min,  a);
        chk({tag, ".y_max"},  y_max,  b);
        chk({tag, ".cb_min"}, cb_min, c);
        chk({tag, ".cb_max"}, cb_max, d);
        chk({tag, ".cr_min"}, cr_min, e);
        chk({tag, ".cr_max"}, cr_max, f);
    endtask

    // Advance one clock; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            thr_de   = 1'b1;
            thr_data = 1'b1;
            tick();
        end
        thr_de   = 1'b0;
        thr_data = 1'b0;
    endtask

    // One idle cycle with in_vs low, then the boundary edge (optionally with a hit)
    task automatic frame_edge(input logic h);
        tick();
        in_vs    = 1'b1;
        thr_de   = h;
        thr_data = h;
        tick();
        in_vs    = 1'b0;
        thr_de   = 1'b0;
        thr_data = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        sel_set = 2'd0; scan_en = 1'b0; in_vs = 1'b0; in_de = 1'b0;
        thr_data = 1'b0; thr_de = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_thr("rst", 50, 200, 133, 173, 77, 127);
        chk("rst.act_set", act_set, 0);
        chk("rst.hit_cnt", hit_cnt, 0);
        chk("rst.frame_start", frame_start, 0);
        chk("rst.hit_valid", hit_valid, 0);
        chk("rst.fsm", fsm_state, 0);
        rst_n = 1'b1;

        // First boundary: defaults, pulse, no report
        frame_edge(1'b0);
        chk_thr("b1", 50, 200, 133, 173, 77, 127);
        chk("b1.frame_start", frame_start, 1);
        chk("b1.hit_valid", hit_valid, 0);
        chk("b1.act_set", act_set, 0);
        chk("b1.fsm", fsm_state, 1);
        tick();
        chk("b1.frame_start_end", frame_start, 0);

        // Write set 2 y_min mid-frame, then activate set 2
        cfg_write(5'b10000, 8'd90);
        chk("wr.cfg_err", cfg_err, 0);
        chk("wr.y_min_hold", y_min, 50);
        sel_set = 2'd2;
        frame_edge(1'b0);
        chk_thr("b2", 90, 200, 133, 173, 77, 127);
        chk("b2.act_set", act_set, 2);
        chk("b2.hit_valid", hit_valid, 1);
        chk("b2.hit_cnt", hit_cnt, 0);
        chk("b2.hit_set", hit_set, 0);

        // 1000 hits plus qualifier-only cycles that must not count
        thr_de = 1'b1; thr_data = 1'b0; tick();
        thr_de = 1'b0; thr_data = 1'b1; tick();
        thr_data = 1'b0;
        hits(1000);
        frame_edge(1'b0);
        chk("b3.hit_valid", hit_valid, 1);
        chk("b3.hit_cnt", hit_cnt, 1000);
        chk("b3.hit_set", hit_set, 2);
        tick();
        chk("b3.hit_valid_end", hit_valid, 0);

        // Auto-scan over five frames starting from set 0
        sel_set = 2'd0;
        frame_edge(1'b0);
        chk("scan0.act_set", act_set, 0);
        scan_en  = 1'b1;
        prev_act = 2'd0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'(prev_act));
            sel_set = 2'($urandom_range(0, 3));
            frame_edge(1'b0);
            exp_act = 2'((i + 1) % 4);
            chk("scan.act_set", act_set, exp_act);
            chk("scan.hit_set", hit_set, exp_q.pop_front());
            chk("scan.y_min", y_min, (exp_act == 2'd2) ? 90 : 50);
            prev_act = exp_act;
        end
        scan_en = 1'b0;

        // Write on the boundary cycle into the set being loaded
        sel_set = 2'd1;
        tick();
        cfg_we = 1'b1; cfg_addr = 5'b01101; cfg_wdata = 8'd140; in_vs = 1'b1;
        tick();
        cfg_we = 1'b0; in_vs = 1'b0;
        chk("byp.frame_start", frame_start, 1);
        chk("byp.act_set", act_set, 1);
        chk_thr("byp", 50, 200, 133, 173, 77, 140);

        // Write to register index 6 is rejected with an error pulse
        cfg_write(5'b01110, 8'hFF);
        chk("err.cfg_err", cfg_err, 1);
        tick();
        chk("err.cfg_err_end", cfg_err, 0);
        chk_thr("err", 50, 200, 133, 173, 77, 140);

        // Mid-frame write to the active set waits for the next boundary
        cfg_write(5'b01001, 8'd10);
        chk("mid.y_max_hold", y_max, 200);
        frame_edge(1'b0);
        chk_thr("mid", 50, 10, 133, 173, 77, 140);

        // Saturation with a 4-bit counter, and a hit on the boundary cycle
        sel_set = 2'd0;
        frame_edge(1'b0);
        hits(20);
        frame_edge(1'b0);
        chk("sat.hit_cnt", hit_cnt, 20);
        chk("sat.hit_cnt4", hit_cnt4, 15);
        chk("sat.hit_valid4", hit_valid4, 1);
        hits(3);
        frame_edge(1'b1);
        chk("coin.old_frame", hit_cnt, 3);
        chk("coin.old_frame4", hit_cnt4, 3);
        hits(2);
        frame_edge(1'b0);
        chk("coin.new_frame", hit_cnt, 3);
        chk("coin.new_frame4", hit_cnt4, 3);

        // Asynchronous reset mid-frame with in_vs held high through release
        hits(5);
        rst_n = 1'b0;
        in_vs = 1'b1;
        #2;
        chk("arst.hit_cnt", hit_cnt, 0);
        chk("arst.fsm", fsm_state, 0);
        chk("arst.act_set", act_set, 0);
        chk("arst.cr_max", cr_max, 127);
        chk("arst.y_max", y_max, 200);
        tick();
        rst_n   = 1'b1;
        sel_set = 2'd1;
        tick();
        chk("rel.frame_start", frame_start, 1);
        chk("rel.hit_valid", hit_valid, 0);
        chk("rel.act_set", act_set, 1);
        chk("rel.fsm", fsm_state, 1);
        chk_thr("rel", 50, 200, 133, 173, 77, 127);
        in_vs = 1'b0;
        frame_edge(1'b0);
        chk("rel.report_valid", hit_valid, 1);
        chk("rel.report_cnt", hit_cnt, 0);
        chk("rel.report_set", hit_set, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
